// File: rtl/prng_mask_gen.sv
// prng_mask_gen: multi-lane xorshift128 mask generator with a registered output FIFO,
// seed handshake, reseed advisory counter and optional repetition alarm.
// Optional feature macro: PRNG_MASK_REPEAT_CHK_EN (repetition check on each lane).
module prng_mask_gen #(
   parameter int unsigned NUM_LANES       = 2,
   parameter int unsigned FIFO_DEPTH      = 4,
   parameter int unsigned RESEED_INTERVAL = 1024
) (
   input  logic                                  clk,
   input  logic                                  rst,
   input  logic                                  seed_valid_i,
   output logic                                  seed_ready_o,
   input  logic [128*NUM_LANES-1:0]              seed_i,
   output logic                                  mask_valid_o,
   input  logic                                  mask_ready_i,
   output logic [128*NUM_LANES-1:0]              mask_o,
   output logic [$clog2(FIFO_DEPTH):0]           level_o,
   output logic                                  seeded_o,
   output logic                                  reseed_req_o,
   output logic                                  alarm_o
);

   localparam int unsigned W  = 128 * NUM_LANES;
   localparam int unsigned PW = $clog2(FIFO_DEPTH);
   localparam int unsigned LW = PW + 1;
   localparam int unsigned CW = (RESEED_INTERVAL > 0) ? $clog2(RESEED_INTERVAL + 1) : 1;
   localparam logic [127:0] ResetState = 128'hdeadbeef_cafebabe_12345678_87654321;

   typedef enum logic [1:0] {StUnseeded, StRun, StAlarm} state_e;

   state_e            state_q, state_d;
   logic [127:0]      lane_q [NUM_LANES];
   logic [127:0]      lane_d [NUM_LANES];
   logic [127:0]      lane_next [NUM_LANES];
   logic [W-1:0]      word_next;
   logic [W-1:0]      fifo_mem [FIFO_DEPTH];
   logic [PW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [LW-1:0]     level_q, level_d;
   logic [CW-1:0]     use_cnt_q, use_cnt_d;
   logic              seeded_q, seeded_d;
   logic              reseed_q, reseed_d;
   logic              seed_acc, pop, room, gen, push, flush, alarm_hit;

   // One xorshift128 step on a single 128-bit lane state {x, y, z, w}.
   function automatic logic [127:0] xs_step(input logic [127:0] s);
      logic [31:0] x, y, z, w, t;
      x = s[127:96];
      y = s[95:64];
      z = s[63:32];
      w = s[31:0];
      t = x ^ (x << 11);
      return {y, z, w, w ^ (w >> 19) ^ t ^ (t >> 8)};
   endfunction

   // Handshakes and generation enable; generation sees room after this cycle's pop.
   always_comb begin
      seed_ready_o = (state_q != StAlarm);
      seed_acc     = seed_valid_i && seed_ready_o;
      mask_valid_o = (level_q != '0) && (state_q != StAlarm);
      pop          = mask_valid_o && mask_ready_i;
      room         = !((level_q == LW'(FIFO_DEPTH)) && !pop);
      gen          = (state_q == StRun) && !seed_acc && room;
      flush        = seed_acc || alarm_hit;
      push         = gen && !flush;
   end

   // Per-lane next state and the concatenated word pushed into the FIFO.
   always_comb begin
      word_next = '0;
      for (int k = 0; k < NUM_LANES; k++) begin
         lane_next[k]           = xs_step(lane_q[k]);
         word_next[128*k +: 128] = lane_next[k];
      end
   end

   // Lane state update: seed load (zero slice replaced by k+1), step, or hold.
   always_comb begin
      for (int k = 0; k < NUM_LANES; k++) begin
         lane_d[k] = lane_q[k];
         if (seed_acc) begin
            lane_d[k] = (seed_i[128*k +: 128] == '0) ? 128'(k + 1) : seed_i[128*k +: 128];
         end else if (gen) begin
            lane_d[k] = lane_next[k];
         end
      end
   end

   // FIFO pointers and occupancy; a seed or alarm discards all buffered words.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         level_d  = '0;
      end else begin
         if (push) wr_ptr_d = wr_ptr_q + PW'(1);
         if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
         level_d = level_q + LW'(push) - LW'(pop);
      end
   end

   // Use counter saturates at the interval; the request is sticky until a seed.
   always_comb begin
      use_cnt_d = use_cnt_q;
      reseed_d  = reseed_q;
      seeded_d  = seeded_q || seed_acc;
      if (seed_acc) begin
         use_cnt_d = '0;
         reseed_d  = 1'b0;
      end else begin
         if (pop && (use_cnt_q != CW'(RESEED_INTERVAL))) use_cnt_d = use_cnt_q + CW'(1);
         if ((RESEED_INTERVAL != 0) && (use_cnt_d == CW'(RESEED_INTERVAL))) reseed_d = 1'b1;
      end
   end

   // FSM next state.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StUnseeded: if (seed_acc) state_d = StRun;
         StRun:      if (alarm_hit) state_d = StAlarm;
         StAlarm:    state_d = StAlarm;
         default:    state_d = StUnseeded;
      endcase
   end

   // Control and lane state registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= StUnseeded;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         level_q   <= '0;
         use_cnt_q <= '0;
         seeded_q  <= 1'b0;
         reseed_q  <= 1'b0;
         for (int k = 0; k < NUM_LANES; k++) lane_q[k] <= ResetState ^ 128'(k);
      end else begin
         state_q   <= state_d;
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         level_q   <= level_d;
         use_cnt_q <= use_cnt_d;
         seeded_q  <= seeded_d;
         reseed_q  <= reseed_d;
         for (int k = 0; k < NUM_LANES; k++) lane_q[k] <= lane_d[k];
      end
   end

   // FIFO storage; stale entries are never visible because level gates the head.
   always_ff @(posedge clk) begin
      if (push) fifo_mem[wr_ptr_q] <= word_next;
   end

   assign mask_o       = mask_valid_o ? fifo_mem[rd_ptr_q] : '0;
   assign level_o      = level_q;
   assign seeded_o     = seeded_q;
   assign reseed_req_o = reseed_q;

`ifdef PRNG_MASK_REPEAT_CHK_EN
   logic [127:0] prev_q [NUM_LANES];
   logic         skip_q;
   logic         alarm_q;

   // A lane repeating its previous output is a stuck generator; first push after a seed is exempt.
   always_comb begin
      alarm_hit = 1'b0;
      for (int k = 0; k < NUM_LANES; k++) begin
         if (gen && !skip_q && (lane_next[k] == prev_q[k])) alarm_hit = 1'b1;
      end
   end

   // Repetition-check history and sticky alarm.
   always_ff @(posedge clk) begin
      if (rst) begin
         skip_q  <= 1'b1;
         alarm_q <= 1'b0;
         for (int k = 0; k < NUM_LANES; k++) prev_q[k] <= '0;
      end else begin
         if (seed_acc) skip_q <= 1'b1;
         else if (gen) skip_q <= 1'b0;
         if (gen) begin
            for (int k = 0; k < NUM_LANES; k++) prev_q[k] <= lane_next[k];
         end
         if (alarm_hit) alarm_q <= 1'b1;
      end
   end

   assign alarm_o = alarm_q;
`else
   assign alarm_hit = 1'b0;
   assign alarm_o   = 1'b0;
`endif

endmodule

// File: tb/tb_prng_mask_gen.sv
// tb_prng_mask_gen: randomized bench for prng_mask_gen against a transaction-level model.
module tb_prng_mask_gen;

   localparam int unsigned NL = 2;
   localparam int unsigned W  = 128 * NL;
   localparam int          D  = 4;
   localparam int          RI = 8;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          seed_valid_i = 1'b0;
   logic          seed_ready_o;
   logic [W-1:0]  seed_i = '0;
   logic          mask_valid_o;
   logic          mask_ready_i = 1'b0;
   logic [W-1:0]  mask_o;
   logic [2:0]    level_o;
   logic          seeded_o;
   logic          reseed_req_o;
   logic          alarm_o;

   int n_checks = 0;
   int n_fail   = 0;

   // Model: output stream position per lane, occupancy, handshake count.
   logic [127:0] m_st [NL];
   int           m_lvl    = 0;
   int           m_hs     = 0;
   logic         m_seeded = 1'b0;
   logic         m_req    = 1'b0;

   prng_mask_gen #(
      .NUM_LANES(NL),
      .FIFO_DEPTH(D),
      .RESEED_INTERVAL(RI)
   ) dut (
      .clk(clk),
      .rst(rst),
      .seed_valid_i(seed_valid_i),
      .seed_ready_o(seed_ready_o),
      .seed_i(seed_i),
      .mask_valid_o(mask_valid_o),
      .mask_ready_i(mask_ready_i),
      .mask_o(mask_o),
      .level_o(level_o),
      .seeded_o(seeded_o),
      .reseed_req_o(reseed_req_o),
      .alarm_o(alarm_o)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [127:0] xs(input logic [127:0] s);
      logic [31:0] x, y, z, w, t;
      {x, y, z, w} = s;
      t = x ^ (x << 11);
      return {y, z, w, w ^ (w >> 19) ^ t ^ (t >> 8)};
   endfunction

   function automatic logic [W-1:0] rand_seed();
      logic [W-1:0] s;
      for (int i = 0; i < W / 32; i++) s[32*i +: 32] = $urandom;
      if ($urandom_range(3) == 0) s[127:0] = '0;
      if ($urandom_range(3) == 0) s[255:128] = '0;
      return s;
   endfunction

   // One clock cycle: drive inputs, compare outputs with the model, advance the model.
   task automatic run_cycle(input logic rdy, input logic sv, input logic [W-1:0] sd);
      logic         pop, push;
      logic [W-1:0] exp_word;
      #1;
      mask_ready_i = rdy;
      seed_valid_i = sv;
      seed_i       = sd;
      #1;
      check("valid", mask_valid_o, m_lvl != 0);
      check("level", level_o, m_lvl);
      check("seeded", seeded_o, m_seeded);
      check("reseed_req", reseed_req_o, m_req);
      check("alarm", alarm_o, 1'b0);
      check("seed_ready", seed_ready_o, 1'b1);
      pop = rdy && (m_lvl != 0);
      if (pop) begin
         for (int k = 0; k < NL; k++) begin
            m_st[k] = xs(m_st[k]);
            exp_word[128*k +: 128] = m_st[k];
         end
         check("mask", mask_o, exp_word);
         if (m_hs < RI) m_hs++;
      end
      push = m_seeded && !sv && ((m_lvl - int'(pop)) < D);
      if (sv) begin
         for (int k = 0; k < NL; k++)
            m_st[k] = (sd[128*k +: 128] == '0) ? 128'(k + 1) : sd[128*k +: 128];
         m_lvl    = 0;
         m_hs     = 0;
         m_seeded = 1'b1;
      end else begin
         m_lvl = m_lvl - int'(pop) + int'(push);
      end
      m_req = (RI != 0) && (m_hs >= RI);
      @(posedge clk);
   endtask

   // Synchronous reset with handshakes in flight, then check reset values.
   task automatic reset_dut();
      #1;
      rst          = 1'b1;
      mask_ready_i = 1'b1;
      seed_valid_i = 1'b1;
      seed_i       = rand_seed();
      @(posedge clk);
      @(posedge clk);
      #1;
      rst          = 1'b0;
      seed_valid_i = 1'b0;
      check("rst_valid", mask_valid_o, 1'b0);
      check("rst_mask", mask_o, '0);
      check("rst_level", level_o, 3'd0);
      check("rst_seeded", seeded_o, 1'b0);
      check("rst_reseed", reseed_req_o, 1'b0);
      check("rst_alarm", alarm_o, 1'b0);
      m_lvl    = 0;
      m_hs     = 0;
      m_seeded = 1'b0;
      m_req    = 1'b0;
   endtask

   logic [W-1:0] head;

   initial begin
      reset_dut();
      // Unseeded: no output regardless of ready.
      repeat (20) run_cycle(1'b1, 1'b0, '0);
      // All-zero seed: lanes load 1 and 2.
      run_cycle(1'b1, 1'b1, '0);
      run_cycle(1'b1, 1'b0, '0);
      #2;
      check("first_lane0", mask_o[127:0], 128'h00000000_00000000_00000001_00000001);
      check("first_lane1", mask_o[255:128], 128'h00000000_00000000_00000002_00000002);
      run_cycle(1'b1, 1'b0, '0);
      #2;
      check("second_lane0", mask_o[127:0], 128'h00000000_00000001_00000001_00000001);
      // Continuous pops across the reseed interval.
      repeat (12) run_cycle(1'b1, 1'b0, '0);
      // Stall: FIFO fills and the head holds.
      run_cycle(1'b0, 1'b0, '0);
      #2;
      head = mask_o;
      repeat (6) begin
         run_cycle(1'b0, 1'b0, '0);
         #2;
         check("head_stable", mask_o, head);
      end
      repeat (10) run_cycle(1'b1, 1'b0, '0);
      // Mid-stream seed with a simultaneous pop.
      run_cycle(1'b1, 1'b1, rand_seed());
      repeat (15) run_cycle(1'b1, 1'b0, '0);
      // Random traffic with occasional reseeds.
      repeat (400) run_cycle($urandom_range(9) < 7, $urandom_range(39) == 0, rand_seed());
      // Reset mid-operation, then resume.
      reset_dut();
      repeat (5) run_cycle(1'b1, 1'b0, '0);
      run_cycle($urandom_range(1) == 1, 1'b1, rand_seed());
      repeat (100) run_cycle($urandom_range(3) != 0, $urandom_range(49) == 0, rand_seed());
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/prng_mask_gen.md
Name: prng_mask_gen

Overview:
Parametrised multi-lane xorshift128 mask generator for masked AES datapaths. It delivers 128*NUM_LANES-bit mask words through a valid/ready output FIFO and accepts seeds through a valid/ready handshake. It tracks output usage and requests a reseed after a programmable number of words. It sits between the seed source (TRNG/CSR) and the masked S-box/key-schedule logic.

Parameters:
NUM_LANES, 2, number of independent xorshift128 lanes; word width W = 128*NUM_LANES; lane k occupies bits [128k+127:128k]
FIFO_DEPTH, 4, output buffer entries; power of two, >= 2
RESEED_INTERVAL, 1024, accepted output words before reseed_req_o asserts; 0 = never request

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
seed_valid_i  in  1  seed offered
seed_ready_o  out  1  seed can be accepted
seed_i  in  W  seed, per-lane 128-bit slices
mask_valid_o  out  1  FIFO head valid
mask_ready_i  in  1  consumer takes head
mask_o  out  W  FIFO head word
level_o  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy
seeded_o  out  1  at least one seed accepted since reset
reseed_req_o  out  1  reseed interval reached; sticky until next seed
alarm_o  out  1  repetition-check alarm; see Optional Feature

Behaviour:
- Reset values:
  - lane k state = 128'hdeadbeef_cafebabe_12345678_87654321 ^ k
  - FIFO empty; mask_valid_o=0; mask_o=0; level_o=0
  - seeded_o=0; reseed_req_o=0; alarm_o=0; use counter=0; FSM=UNSEEDED
- seed_ready_o = 1 in UNSEEDED and RUN; 0 in ALARM. A seed is accepted when seed_valid_i && seed_ready_o.
- Zero-seed rule: a lane slice equal to 0 loads 128'(k+1) instead.
- xorshift step, per lane, with {x,y,z,w} = state[127:96], [95:64], [63:32], [31:0]:
  - t = x^(x<<11)
  - next = {y, z, w, w^(w>>19)^t^(t>>8)}
- FSM states and transitions:
  - UNSEEDED: no generation, FIFO empty. Seed accepted -> RUN.
  - RUN: each cycle with FIFO not full (after the pop in that same cycle), all lanes step. The FIFO is pushed with the concatenated next states, and state <= next. The raw seed is never output.
  - ALARM: entered only with the optional feature. No generation. mask_valid_o=0 and FIFO flushed. Left only by rst.
- Seed accept in cycle N:
  - Lane states load at N+1; FIFO flushed at N+1; no push in cycle N.
  - use counter := 0; reseed_req_o := 0; seeded_o := 1.
  - First push occurs in cycle N+1, so mask_valid_o=1 from cycle N+2.
  - A pop in cycle N is honoured; the consumer receives the old head.
- FIFO:
  - Registered; mask_o is driven from the head entry.
  - Push and pop in the same cycle when full is allowed; level is unchanged.
  - Pop when empty is ignored. Pointers wrap modulo FIFO_DEPTH.
  - Steady state delivers one word per cycle.
- Use counter:
  - Increments on each output handshake (mask_valid_o && mask_ready_i) and saturates at RESEED_INTERVAL.
  - reseed_req_o=1 the cycle after it reaches RESEED_INTERVAL.
  - Output continues while reseed_req_o=1; the request is advisory.
- Reset mid-operation returns every state to its reset value in the next cycle, regardless of handshakes in flight.

Optional Feature:
PRNG_MASK_REPEAT_CHK_EN
- Defined:
  - Each lane keeps its last generated 128-bit value.
  - If any lane's new value equals its previous value, alarm_o=1 (sticky) from the next cycle and the FSM enters ALARM.
  - The comparison is skipped for the first push after each seed accept.
- Undefined: alarm_o tied 0, no comparison registers, ALARM state unreachable.

Test Plan:
- Reset, no seed, mask_ready_i=1 for 20 cycles -> mask_valid_o=0, seeded_o=0, level_o=0 throughout.
- NUM_LANES=1, seed 128'h1, mask_ready_i=1 -> first word 128'h00000000_00000000_00000001_00000001, second 128'h00000000_00000001_00000001_00000001; mask_valid_o first high 2 cycles after accept.
- NUM_LANES=2, seed all-zero -> lane0 loads 128'h1 and lane1 loads 128'h2; first lane0 output 128'h00000000_00000000_00000001_00000001.
- mask_ready_i=0 after seeding -> level_o reaches FIFO_DEPTH (4) and holds; the head word is stable; ready=1 then drains one word per cycle with no gaps or duplicates versus the reference model.
- RESEED_INTERVAL=8, continuous pops -> reseed_req_o rises after the 8th handshake and output continues; new seed accepted mid-stream with simultaneous pop -> popped word is the old head, then FIFO is flushed and reseed_req_o=0.
- With PRNG_MASK_REPEAT_CHK_EN, force a lane state to repeat -> alarm_o=1 next cycle, mask_valid_o=0, seed_ready_o=0 until rst; without the macro, alarm_o stays 0.
